ps2_frame_rx: RTL
=================

Name: ps2_frame_rx

Overview:
- PS/2 device-to-host receiver that sits directly upstream of keyboard_ctl.
- Synchronises and glitch-filters the raw ps2_clk/ps2_data pins, then deserialises 11-bit frames (start, 8 data LSB-first, odd parity, stop).
- Delivers each accepted scan-code byte as a 16-bit keycode with its E0/F0 prefix, plus a one-cycle oflag strobe.
- keyboard_ctl decodes these into key_space/key_left/key_right.

Parameters:
- FILTER_LEN, 8: consecutive equal samples needed before filtered ps2_clk changes level.
- TIMEOUT_CYCLES, 200000: cycles without a filtered ps2_clk falling edge before an in-progress frame is aborted (2 ms at 100 MHz).

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  reset, asynchronous, active-low.
- ps2_clk  in  1  raw PS/2 clock pin, asynchronous, idle high.
- ps2_data  in  1  raw PS/2 data pin, asynchronous, idle high.
- keycode  out  16  {prefix_byte or 8'h00, scan_byte}; held between updates.
- oflag  out  1  one-cycle strobe, keycode valid/new.
- err  out  1  one-cycle strobe, frame rejected on parity or stop-bit failure.
- busy  out  1  high while a frame is in progress (state != IDLE).

Behaviour:
- Reset (rst=0, async):
  - keycode=16'h0000, oflag=0, err=0, busy=0, state=IDLE.
  - Sync and filter flops set to 1; prefix register cleared; timeout counter cleared.
  - Reset mid-frame discards the partial frame. No oflag or err is generated.
- Input path: 2-flop synchroniser on each pin, then a FILTER_LEN shift register on the synced clock.
  - Filtered clock goes 0 only when all FILTER_LEN samples are 0, and goes 1 only when all are 1. Otherwise it holds.
  - fall = registered (filt_d & ~filt). Data is sampled from the synced ps2_data in the cycle fall is high.
  - Pulses shorter than FILTER_LEN cycles are ignored.
- FSM (advances only on fall, except timeout):
  - IDLE: data=0 goes to DATA with bit_cnt=0. data=1 is a false start; stay in IDLE.
  - DATA: shift sampled bit into shreg[7] (shift right, LSB first) and increment bit_cnt. After the 8th bit, go to PARITY.
  - PARITY: store the bit; go to STOP.
  - STOP:
    - If data=1 and ^{shreg,parity}==1, accept the byte.
    - Otherwise pulse err.
    - Either way, return to IDLE.
- Timeout: the counter resets on every fall and increments otherwise while state != IDLE. When it reaches TIMEOUT_CYCLES-1:
  - return to IDLE;
  - discard the partial frame;
  - no err, no oflag.
- Byte acceptance, in the cycle after the STOP decision:
  - oflag=1 for exactly one cycle, with keycode updated in the same cycle.
  - keycode = {pfx, byte}, where pfx is the previously accepted byte if that byte was 8'hE0 or 8'hF0, otherwise 8'h00.
  - The prefix register then takes the new byte.
  - Prefix bytes themselves produce oflag: F0 gives 16'h00F0.
  - Sequence E0 F0 74 yields 00E0, E0F0, F074. Only one prefix level is retained.
- A rejected frame leaves keycode and the prefix register unchanged.
- Latency: oflag rises exactly FILTER_LEN+4 clk cycles after the first clk edge that samples ps2_clk low for the stop bit. Stages: 2 sync, FILTER_LEN filter, 1 fall register, 1 output register.
- A new start bit arriving in the same cycle as oflag is handled normally; the FSM is already in IDLE.

Decomposition:
- ps2_pkg:
  - state enum {IDLE, DATA, PARITY, STOP};
  - PS2_PFX_EXT=8'hE0, PS2_PFX_BRK=8'hF0;
  - PS2_DATA_BITS=8.
- Sub-module ps2_line_filter: synchroniser plus glitch filter plus registered fall detect, parameterised by FILTER_LEN. Instantiated once for ps2_clk; also outputs the synced ps2_data.
- Top holds the FSM, timeout counter, prefix register and outputs.

Test Plan:
- Frame 0x29 (valid parity, 20 µs PS/2 period) -> single oflag pulse at FILTER_LEN+4 after stop edge; keycode=16'h0029; err never high.
- Frames F0 then 29 -> oflag twice; keycode 16'h00F0 then 16'hF029. Then frame 29 -> 16'h0029 (prefix cleared).
- Frame 0x1C with flipped parity bit -> err one-cycle pulse, no oflag, keycode retains prior value. Repeat with stop bit=0 -> same result.
- Start plus 4 data bits, then idle for TIMEOUT_CYCLES -> busy falls exactly then, no flags. Next frame 0x6B -> keycode=16'h006B.
- Glitches of FILTER_LEN-1 cycles low on ps2_clk while idle and mid-frame -> ignored; the subsequent frame 0x74 decodes to 16'h0074.
- rst asserted after 5 bits of a frame -> outputs go to reset values immediately. After release, a full frame 0x29 -> keycode=16'h0029, with no spurious flag from the aborted frame.

Source files
------------

// File: rtl/ps2_frame_rx_pkg.sv
// Shared types and constants for the PS/2 device-to-host frame receiver.
package ps2_frame_rx_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      PARITY,
      STOP
   } ps2_state_e;

   localparam logic [7:0]  PS2_PFX_EXT   = 8'hE0;
   localparam logic [7:0]  PS2_PFX_BRK   = 8'hF0;
   localparam int unsigned PS2_DATA_BITS = 8;

   function automatic logic is_prefix(input logic [7:0] b);
      return (b == PS2_PFX_EXT) || (b == PS2_PFX_BRK);
   endfunction

endpackage

// File: rtl/ps2_frame_rx_if.sv
// Pin and result bundle between the PS/2 pins, the receiver and keyboard_ctl.
interface ps2_frame_rx_if;

   logic        ps2_clk;
   logic        ps2_data;
   logic [15:0] keycode;
   logic        oflag;
   logic        err;
   logic        busy;

   modport master (
      output ps2_clk,
      output ps2_data,
      input  keycode,
      input  oflag,
      input  err,
      input  busy
   );

   modport slave (
      input  ps2_clk,
      input  ps2_data,
      output keycode,
      output oflag,
      output err,
      output busy
   );

endinterface

// File: rtl/ps2_frame_rx_line_filter.sv
// Two-flop synchronisers on both pins, majority-free glitch filter on the clock
// and a registered falling-edge strobe of the filtered clock.
module ps2_line_filter #(
   parameter int unsigned FILTER_LEN = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic ps2_clk_i,
   input  logic ps2_data_i,
   output logic data_sync_o,
   output logic fall_o
);

   logic [1:0]            clk_sync_q;
   logic [1:0]            data_sync_q;
   logic [FILTER_LEN-1:0] hist_q;
   logic                  filt_q;
   logic                  filt_d;
   logic                  fall_q;

   // Level only changes once the whole history agrees; mixed history holds.
   always_comb begin
      filt_d = filt_q;
      if (hist_q == '0) begin
         filt_d = 1'b0;
      end else if (hist_q == '1) begin
         filt_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         clk_sync_q  <= '1;
         data_sync_q <= '1;
         hist_q      <= '1;
         filt_q      <= 1'b1;
         fall_q      <= 1'b0;
      end else begin
         clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
         data_sync_q <= {data_sync_q[0], ps2_data_i};
         hist_q      <= {hist_q[FILTER_LEN-2:0], clk_sync_q[1]};
         filt_q      <= filt_d;
         fall_q      <= filt_q & ~filt_d;
      end
   end

   assign data_sync_o = data_sync_q[1];
   assign fall_o      = fall_q;

endmodule

// File: rtl/ps2_frame_rx.sv
// PS/2 frame deserialiser: start/8 data/odd parity/stop, with E0/F0 prefix
// tracking, frame timeout and one-cycle oflag/err strobes.
module ps2_frame_rx
   import ps2_frame_rx_pkg::*;
#(
   parameter int unsigned FILTER_LEN     = 8,
   parameter int unsigned TIMEOUT_CYCLES = 200000
) (
   input  logic          clk,
   input  logic          rst,
   ps2_frame_rx_if.slave bus
);

   localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int unsigned BIT_W = $clog2(PS2_DATA_BITS);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(PS2_DATA_BITS - 1);

   logic fall;
   logic data_s;

   ps2_line_filter #(
      .FILTER_LEN(FILTER_LEN)
   ) u_line_filter (
      .clk        (clk),
      .rst        (rst),
      .ps2_clk_i  (bus.ps2_clk),
      .ps2_data_i (bus.ps2_data),
      .data_sync_o(data_s),
      .fall_o     (fall)
   );

   ps2_state_e               state_q;
   logic [BIT_W-1:0]         bit_cnt_q;
   logic [PS2_DATA_BITS-1:0] shreg_q;
   logic                     parity_q;
   logic [TMO_W-1:0]         tmo_q;
   logic                     done_q;
   logic                     done_ok_q;
   logic [7:0]               pfx_q;
   logic [15:0]              keycode_q;
   logic                     oflag_q;
   logic                     err_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         bit_cnt_q <= '0;
         shreg_q   <= '0;
         parity_q  <= 1'b0;
         tmo_q     <= '0;
         done_q    <= 1'b0;
         done_ok_q <= 1'b0;
         pfx_q     <= '0;
         keycode_q <= '0;
         oflag_q   <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         // Output stage: the STOP verdict is published one cycle later.
         done_q  <= 1'b0;
         oflag_q <= done_q & done_ok_q;
         err_q   <= done_q & ~done_ok_q;
         if (done_q && done_ok_q) begin
            keycode_q <= {(is_prefix(pfx_q) ? pfx_q : 8'h00), shreg_q};
            pfx_q     <= shreg_q;
         end

         if (state_q == IDLE) begin
            tmo_q <= '0;
            if (fall && !data_s) begin
               state_q   <= DATA;
               bit_cnt_q <= '0;
            end
         end else if (fall) begin
            tmo_q <= '0;
            unique case (state_q)
               DATA: begin
                  shreg_q   <= {data_s, shreg_q[PS2_DATA_BITS-1:1]};
                  bit_cnt_q <= bit_cnt_q + 1'b1;
                  if (bit_cnt_q == BIT_LAST) begin
                     state_q <= PARITY;
                  end
               end
               PARITY: begin
                  parity_q <= data_s;
                  state_q  <= STOP;
               end
               STOP: begin
                  done_q    <= 1'b1;
                  done_ok_q <= data_s & (^{shreg_q, parity_q});
                  state_q   <= IDLE;
               end
               default: state_q <= IDLE;
            endcase
         end else if (tmo_q == TMO_LAST) begin
            state_q <= IDLE;
            tmo_q   <= '0;
         end else begin
            tmo_q <= tmo_q + 1'b1;
         end
      end
   end

   assign bus.keycode = keycode_q;
   assign bus.oflag   = oflag_q;
   assign bus.err     = err_q;
   assign bus.busy    = (state_q != IDLE);

endmodule
